// File: rtl/back_page_writer.sv
// back_page_writer: clears the non-displayed frame-buffer page after every page swap,
// then turns draw-engine pixel requests into linear frame-buffer writes.
module back_page_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int PIX_W = 8,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
  input  logic             VGA_CLK,
  input  logic             RESET_N,
  input  logic             PAGE_SEL,
  input  logic             DRAW_VALID,
  input  logic [9:0]       DRAW_X,
  input  logic [9:0]       DRAW_Y,
  input  logic [PIX_W-1:0] DRAW_COLOR,
  output logic             DRAW_READY,
  output logic             MEM_WE,
  output logic [19:0]      MEM_ADDR,
  output logic [PIX_W-1:0] MEM_DATA,
  input  logic             MEM_READY,
  output logic             CLEARING,
  output logic             FRAME_START
);
  typedef enum logic {CLEAR, DRAW} state_e;
  localparam logic [18:0] N_PIX = 19'(H_RES * V_RES);
  state_e           state_q;
  logic             sel_q;
  logic             back_q;
  logic             we_q;
  logic             fs_q;
  logic [18:0]      cnt_q;
  logic [19:0]      addr_q;
  logic [PIX_W-1:0] data_q;
  logic             toggle;
  logic             slot;
  logic             in_range;
  logic [18:0]      idx;
  always_comb begin
    toggle     = PAGE_SEL != sel_q;
    slot       = !we_q || MEM_READY;
    DRAW_READY = state_q == DRAW && !toggle && slot;
    in_range   = 32'(DRAW_X) < H_RES && 32'(DRAW_Y) < V_RES;
    idx        = 19'(DRAW_Y) * 19'(H_RES) + 19'(DRAW_X);
  end
  assign MEM_WE      = we_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_DATA    = data_q;
  assign CLEARING    = state_q == CLEAR;
  assign FRAME_START = fs_q;
  // cnt_q is the next clear index to issue; a pending write is never touched by a swap
  always_ff @(posedge VGA_CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= CLEAR;
      sel_q   <= 1'b0;
      back_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      fs_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      sel_q <= PAGE_SEL;
      fs_q  <= 1'b0;
      if (we_q && MEM_READY) we_q <= 1'b0;
      if (toggle) begin
        back_q  <= ~PAGE_SEL;
        cnt_q   <= '0;
        state_q <= CLEAR;
      end else if (state_q == CLEAR) begin
        if (cnt_q == N_PIX) begin
          if (we_q && MEM_READY) begin
            state_q <= DRAW;
            fs_q    <= 1'b1;
          end
        end else if (slot) begin
          we_q   <= 1'b1;
          addr_q <= {back_q, cnt_q};
          data_q <= CLEAR_COLOR;
          cnt_q  <= cnt_q + 19'd1;
        end
      end else if (DRAW_VALID && DRAW_READY && in_range) begin
        we_q   <= 1'b1;
        addr_q <= {back_q, idx};
        data_q <= DRAW_COLOR;
      end
    end
endmodule

// File: tb/tb_back_page_writer.sv
// tb_back_page_writer: directed stimulus with a transaction-level write-stream model
// and literal expectations; uses a small 64x32 raster to keep clears short.
module tb_back_page_writer;
  localparam int H = 64;
  localparam int V = 32;
  localparam int N = H * V;
  localparam logic [7:0] CC = 8'h3C;

  logic       clk = 1'b0;
  logic       RESET_N, PAGE_SEL, DRAW_VALID, MEM_READY;
  logic [9:0] DRAW_X, DRAW_Y;
  logic [7:0] DRAW_COLOR;
  logic       DRAW_READY, MEM_WE, CLEARING, FRAME_START;
  logic [19:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  back_page_writer #(.H_RES(H), .V_RES(V), .PIX_W(8), .CLEAR_COLOR(CC)) dut (
    .VGA_CLK(clk), .RESET_N(RESET_N), .PAGE_SEL(PAGE_SEL), .DRAW_VALID(DRAW_VALID),
    .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y), .DRAW_COLOR(DRAW_COLOR), .DRAW_READY(DRAW_READY),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .CLEARING(CLEARING), .FRAME_START(FRAME_START)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: the ordered stream of writes still owed to memory, plus clear/frame status
  logic [27:0] eq[$];
  bit m_clear, m_fs, m_sel, m_back, old_front, hold_v, tog, keep, done, exp_ready;
  int clear_left;
  logic [27:0] held, front;

  task automatic push_clear(input bit pg);
    for (int i = 0; i < N; i++) eq.push_back({pg, 19'(i), CC});
    clear_left = N;
  endtask

  task automatic m_reset();
    m_clear = 1; m_fs = 0; m_sel = 0; m_back = 1; old_front = 0; hold_v = 0;
    eq.delete();
    push_clear(1'b1);
  endtask

  always @(negedge clk) begin
    if (!RESET_N) begin
      chk("rst_we", 32'(MEM_WE), 0);
      chk("rst_addr", 32'(MEM_ADDR), 0);
      chk("rst_data", 32'(MEM_DATA), 0);
      chk("rst_clearing", 32'(CLEARING), 1);
      chk("rst_frame_start", 32'(FRAME_START), 0);
      chk("rst_draw_ready", 32'(DRAW_READY), 0);
      m_reset();
    end else begin
      tog = PAGE_SEL != m_sel;
      chk("clearing", 32'(CLEARING), 32'(m_clear));
      chk("frame_start", 32'(FRAME_START), 32'(m_fs));
      exp_ready = !m_clear && !tog && (!MEM_WE || MEM_READY);
      chk("draw_ready", 32'(DRAW_READY), 32'(exp_ready));
      if (hold_v) chk("held_write", {3'b0, MEM_WE, MEM_ADDR, MEM_DATA}, {4'b0001, held});
      if (MEM_WE) begin
        if (eq.size() == 0) chk("spurious_we", 32'(MEM_WE), 0);
        else chk("write", {4'b0, MEM_ADDR, MEM_DATA}, {4'b0, eq[0]});
      end else if (!m_clear && eq.size() > 0) chk("draw_write_missing", 32'(MEM_WE), 1);
      hold_v = MEM_WE && !MEM_READY;
      held = {MEM_ADDR, MEM_DATA};
      m_fs = 0;
      done = 0;
      if (MEM_WE && MEM_READY && eq.size() > 0) begin
        void'(eq.pop_front());
        if (old_front) old_front = 0;
        else if (m_clear && clear_left > 0) begin
          clear_left--;
          done = clear_left == 0;
        end
      end
      if (tog) begin
        keep = MEM_WE && !MEM_READY && eq.size() > 0;
        front = keep ? eq[0] : '0;
        eq.delete();
        if (keep) eq.push_back(front);
        old_front = keep;
        m_sel = PAGE_SEL;
        m_back = !PAGE_SEL;
        m_clear = 1;
        push_clear(!PAGE_SEL);
      end else if (done) begin
        m_clear = 0;
        m_fs = 1;
      end else if (DRAW_VALID && DRAW_READY && DRAW_X < H && DRAW_Y < V)
        eq.push_back({m_back, 19'(int'(DRAW_Y) * H + int'(DRAW_X)), DRAW_COLOR});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic run_clear(input string nm, input int exp_cyc, input int exp_first, input int stall_idx);
    int cyc = 0;
    int wr = 0;
    int seen = 0;
    int left = 0;
    bit got_first = 0;
    bit fin = 0;
    logic [19:0] first = '1;
    while (!fin && cyc < 20000) begin
      @(posedge clk);
      #1;
      MEM_READY = left == 0;
      if (left > 0) left--;
      @(negedge clk);
      cyc++;
      if (MEM_WE && !got_first) begin
        got_first = 1;
        first = MEM_ADDR;
      end
      if (MEM_WE && MEM_READY) wr++;
      if (MEM_WE && int'(MEM_ADDR[18:0]) == stall_idx) seen++;
      if (MEM_WE && MEM_READY && int'(MEM_ADDR[18:0]) == stall_idx - 1) left = 3;
      fin = FRAME_START;
    end
    chk({nm, "_done"}, 32'(fin), 1);
    if (exp_cyc > 0) chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_writes"}, wr, N);
    if (exp_first >= 0) chk({nm, "_first_addr"}, 32'(first), exp_first);
    if (stall_idx >= 0) chk({nm, "_held_cycles"}, seen, 4);
    chk({nm, "_clearing_low"}, 32'(CLEARING), 0);
    chk({nm, "_ready_high"}, 32'(DRAW_READY), 1);
  endtask

  task automatic draw(input int x, input int y, input logic [7:0] c);
    DRAW_VALID = 1;
    DRAW_X = 10'(x);
    DRAW_Y = 10'(y);
    DRAW_COLOR = c;
  endtask

  initial begin
    bit found;
    RESET_N = 0; PAGE_SEL = 0; MEM_READY = 1; DRAW_VALID = 0;
    DRAW_X = 0; DRAW_Y = 0; DRAW_COLOR = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_we", 32'(MEM_WE), 0);
    chk("init_addr", 32'(MEM_ADDR), 0);
    chk("init_clearing", 32'(CLEARING), 1);
    chk("init_ready", 32'(DRAW_READY), 0);
    nxt(); RESET_N = 1;
    run_clear("clr_boot", 2049, 'h80000, -1);
    // single draw, one-cycle latency
    nxt(); draw(10, 2, 8'hA5);
    @(negedge clk); chk("draw1_ready", 32'(DRAW_READY), 1);
    nxt(); DRAW_VALID = 0;
    @(negedge clk);
    chk("draw1_we", 32'(MEM_WE), 1);
    chk("draw1_addr", 32'(MEM_ADDR), 'h8008A);
    chk("draw1_data", 32'(MEM_DATA), 'hA5);
    nxt();
    @(negedge clk); chk("draw1_we_drop", 32'(MEM_WE), 0);
    // out-of-range requests are consumed without writing
    nxt(); draw(64, 0, 8'h11);
    @(negedge clk); chk("oor_x_ready", 32'(DRAW_READY), 1);
    nxt(); draw(0, 32, 8'h22);
    @(negedge clk); chk("oor_y_ready", 32'(DRAW_READY), 1);
    nxt(); DRAW_VALID = 0;
    @(negedge clk); chk("oor_no_we", 32'(MEM_WE), 0);
    // back-to-back draws, including the last pixel
    nxt(); draw(63, 31, 8'h11);
    nxt(); draw(0, 0, 8'h22);
    @(negedge clk);
    chk("b2b_addr1", 32'(MEM_ADDR), 'h807FF);
    chk("b2b_ready", 32'(DRAW_READY), 1);
    nxt(); DRAW_VALID = 0;
    @(negedge clk);
    chk("b2b_addr2", {12'b0, MEM_ADDR}, 'h80000);
    chk("b2b_data2", 32'(MEM_DATA), 'h22);
    // swap to page 0 clear with a 3-cycle memory stall at index 100
    nxt(); PAGE_SEL = 1;
    run_clear("clr_stall", 2053, 'h00000, 100);
    // swap while a draw write is stalled
    nxt(); draw(3, 1, 8'h5A);
    @(negedge clk); chk("pend_ready", 32'(DRAW_READY), 1);
    nxt(); DRAW_VALID = 0; MEM_READY = 0; PAGE_SEL = 0;
    @(negedge clk);
    chk("pend_addr0", 32'(MEM_ADDR), 'h00043);
    chk("pend_data0", 32'(MEM_DATA), 'h5A);
    nxt();
    @(negedge clk);
    chk("pend_addr1", 32'(MEM_ADDR), 'h00043);
    chk("pend_we1", 32'(MEM_WE), 1);
    chk("pend_clearing", 32'(CLEARING), 1);
    chk("pend_ready_low", 32'(DRAW_READY), 0);
    nxt(); MEM_READY = 1;
    @(negedge clk); chk("pend_addr2", 32'(MEM_ADDR), 'h00043);
    run_clear("clr_after_pend", 2049, 'h80000, -1);
    // swap and draw in the same cycle: swap wins
    nxt(); PAGE_SEL = 1; draw(5, 5, 8'h77);
    @(negedge clk); chk("swap_draw_ready", 32'(DRAW_READY), 0);
    nxt(); DRAW_VALID = 0;
    @(negedge clk); chk("swap_no_we", 32'(MEM_WE), 0);
    nxt();
    @(negedge clk);
    chk("swap_first_we", 32'(MEM_WE), 1);
    chk("swap_first_addr", 32'(MEM_ADDR), 'h00000);
    // asynchronous reset in the middle of a clear
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      nxt();
      @(negedge clk);
      found = MEM_WE && MEM_ADDR == 20'd1000;
    end
    chk("midclr_reached", 32'(found), 1);
    #1; RESET_N = 0; PAGE_SEL = 0;
    #1;
    chk("async_we", 32'(MEM_WE), 0);
    chk("async_addr", 32'(MEM_ADDR), 0);
    chk("async_clearing", 32'(CLEARING), 1);
    chk("async_ready", 32'(DRAW_READY), 0);
    repeat (2) @(negedge clk);
    nxt(); RESET_N = 1;
    run_clear("clr_rst", 2049, 'h80000, -1);
    // released with page 1 displayed: clear retargets to page 0
    nxt(); RESET_N = 0; PAGE_SEL = 1;
    @(negedge clk);
    nxt(); RESET_N = 1;
    run_clear("clr_rst_p1", 2050, 'h00000, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
